// File: rtl/reg_cmd_master.sv
// rtl/reg_cmd_master.sv - register-access command initiator: packet out, single-byte reply in
module reg_cmd_master #(
    parameter logic [7:0] MAGIC   = 8'hAA,
    parameter int         TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic [7:0] cmd_out,
    output logic       cmd_wr,
    input  logic       cmd_ready,
    input  logic [7:0] reply_in,
    input  logic       reply_rdy,
    input  logic       reply_end,
    output logic       reply_ack,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic       resp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAGIC,
        S_TYPE,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t     state;
    logic       byte_active;
    logic       write_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] reply_q;
    logic       end_q;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;

    // A byte is only strobed in a cycle the downstream can take it, so the
    // strobe is the registered "byte pending" flag qualified by cmd_ready.
    assign cmd_wr = byte_active & cmd_ready;

    // Saturating increment: the counter parks at 8'hFF instead of wrapping.
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    // Packet sequencer, reply collection and response generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            byte_active <= 1'b0;
            cmd_out     <= 8'h00;
            reply_ack   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= 8'h00;
            resp_err    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            reply_q     <= 8'h00;
            end_q       <= 1'b0;
            wait_cnt    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q     <= req_write;
                        addr_q      <= req_addr;
                        data_q      <= req_data;
                        req_ready   <= 1'b0;
                        byte_active <= 1'b1;
                        cmd_out     <= MAGIC;
                        state       <= S_MAGIC;
                    end
                end
                S_MAGIC: begin
                    if (cmd_ready) begin
                        cmd_out <= {7'b0, write_q};
                        state   <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    if (cmd_ready) begin
                        cmd_out <= addr_q;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cmd_ready) begin
                        cmd_out <= data_q;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cmd_ready) begin
                        byte_active <= 1'b0;
                        cmd_out     <= 8'h00;
                        wait_cnt    <= 8'h00;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt_inc;
                    if (reply_rdy) begin
                        reply_q   <= reply_in;
                        end_q     <= reply_end;
                        reply_ack <= 1'b1;
                        state     <= S_ACK;
                    end else if (wait_cnt_inc == TO_LIM) begin
                        // No reply in time: report an error with no data, never ack.
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 8'h00;
                        state      <= S_DONE;
                    end
                end
                S_ACK: begin
                    // reply_rdy is not looked at here, so a held reply is taken once.
                    reply_ack  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_data  <= reply_q;
                    resp_err   <= ~end_q;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    req_ready   <= 1'b1;
                    byte_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_cmd_master.sv
// tb/tb_reg_cmd_master.sv - self-checking bench for reg_cmd_master
module tb_reg_cmd_master;

    localparam int         TO    = 10;
    localparam logic [7:0] MAGIC = 8'hAA;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic [7:0] cmd_out;
    logic       cmd_wr;
    logic       cmd_ready;
    logic [7:0] reply_in;
    logic       reply_rdy;
    logic       reply_end;
    logic       reply_ack;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;

    reg_cmd_master #(.MAGIC(MAGIC), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .cmd_out   (cmd_out),
        .cmd_wr    (cmd_wr),
        .cmd_ready (cmd_ready),
        .reply_in  (reply_in),
        .reply_rdy (reply_rdy),
        .reply_end (reply_end),
        .reply_ack (reply_ack),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent transaction.
    logic [7:0] bytes[$];
    int         wr_cyc[$];
    logic [7:0] exp_b[4];
    int         ack_n, resp_n, resp_cyc, stall_wr, stall_bad;
    logic       done;
    logic [7:0] got_data;
    logic       got_err;

    // Drives one request plus a scripted responder and records everything seen.
    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rv, input logic re, input int hold,
                           input int delay, input int bp_idx, input int bp_len);
        int stall_left;
        int w;
        int post;
        bytes.delete();
        wr_cyc.delete();
        ack_n = 0; resp_n = 0; resp_cyc = -1; stall_wr = 0; stall_bad = 0;
        done = 1'b0; got_data = 8'h00; got_err = 1'b0;
        exp_b[0] = MAGIC; exp_b[1] = {7'b0, wr}; exp_b[2] = a; exp_b[3] = d;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; cmd_ready = 1'b1;
        stall_left = bp_len; w = 0; post = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            req_valid = done ? 1'b0 : 1'($urandom % 2);
            req_write = 1'($urandom); req_addr = 8'($urandom); req_data = 8'($urandom);
            if (bytes.size() == bp_idx && stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_left--;
            end else begin
                cmd_ready = 1'b1;
            end
            if (bytes.size() == 4) w++;
            if (bytes.size() < 4) begin
                reply_rdy = ($urandom % 4 == 0);
            end else begin
                reply_rdy = (hold > 0 && w > delay && w <= delay + hold);
            end
            reply_in  = (bytes.size() == 4 && reply_rdy) ? rv : 8'($urandom);
            reply_end = (bytes.size() == 4 && reply_rdy) ? re : 1'($urandom);
            @(negedge clk);
            if (!cmd_ready) begin
                if (cmd_wr) stall_wr++;
                if (bytes.size() < 4 && cmd_out !== exp_b[bytes.size()]) stall_bad++;
            end
            if (cmd_wr) begin
                bytes.push_back(cmd_out);
                wr_cyc.push_back(cyc);
            end
            if (reply_ack) ack_n++;
            if (resp_valid) begin
                resp_n++;
                got_data = resp_data;
                got_err  = resp_err;
                resp_cyc = cyc;
                done     = 1'b1;
            end
            if (done) post++;
            if (post >= 4) break;
        end
        req_valid = 1'b0; reply_rdy = 1'b0; cmd_ready = 1'b1;
    endtask

    function automatic logic [31:0] packed_bytes();
        logic [31:0] p = 32'h0;
        foreach (bytes[i]) p = {p[23:0], bytes[i]};
        return p;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_data = 8'h00;
        cmd_ready = 1'b1; reply_in = 8'h00; reply_rdy = 1'b0; reply_end = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (cmd_wr !== 1'b0) begin errors++; $display("FAIL reset_cmd_wr: got %b expected 0", cmd_wr); end
        checks++; if (cmd_out !== 8'h00) begin errors++; $display("FAIL reset_cmd_out: got %h expected 00", cmd_out); end
        checks++; if (reply_ack !== 1'b0) begin errors++; $display("FAIL reset_reply_ack: got %b expected 0", reply_ack); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data: got %h expected 00", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0] d = 8'($urandom);
        int lat;
        run_txn(1'b0, 8'h12, d, 8'h5C, 1'b1, 1, 0, -1, 0);
        lat = (wr_cyc.size() == 4) ? (resp_cyc - wr_cyc[0]) : -1;
        checks++; if (bytes.size() !== 4) begin errors++; $display("FAIL read_nbytes: got %0d expected 4", bytes.size()); end
        checks++; if (packed_bytes() !== {8'hAA, 8'h00, 8'h12, d}) begin errors++; $display("FAIL read_bytes: got %h expected %h", packed_bytes(), {8'hAA, 8'h00, 8'h12, d}); end
        checks++; if (wr_cyc.size() != 4 || wr_cyc[3] - wr_cyc[0] != 3) begin errors++; $display("FAIL read_consecutive: got %0d strobes not back-to-back expected 4 consecutive", wr_cyc.size()); end
        checks++; if (ack_n !== 1) begin errors++; $display("FAIL read_acks: got %0d expected 1", ack_n); end
        checks++; if (resp_n !== 1) begin errors++; $display("FAIL read_resps: got %0d expected 1", resp_n); end
        checks++; if (got_data !== 8'h5C) begin errors++; $display("FAIL read_data: got %h expected 5c", got_data); end
        checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", got_err); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL read_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_write();
        run_txn(1'b1, 8'h03, 8'hA7, 8'hA7, 1'b1, 1, 2, -1, 0);
        checks++; if (packed_bytes() !== 32'hAA0103A7) begin errors++; $display("FAIL write_bytes: got %h expected aa0103a7", packed_bytes()); end
        checks++; if (got_data !== 8'hA7) begin errors++; $display("FAIL write_data: got %h expected a7", got_data); end
        checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL write_err: got %b expected 0", got_err); end
        checks++; if (resp_n !== 1) begin errors++; $display("FAIL write_resps: got %0d expected 1", resp_n); end
    endtask

    task automatic test_backpressure();
        logic [7:0] a = 8'($urandom);
        logic [7:0] d = 8'($urandom);
        run_txn(1'b0, a, d, 8'h33, 1'b1, 1, 0, 2, 3);
        checks++; if (stall_wr !== 0) begin errors++; $display("FAIL bp_cmd_wr: got %0d strobes during stall expected 0", stall_wr); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d cycles with wrong byte expected 0", stall_bad); end
        checks++; if (bytes.size() !== 4) begin errors++; $display("FAIL bp_nbytes: got %0d expected 4", bytes.size()); end
        checks++; if (packed_bytes() !== {8'hAA, 8'h00, a, d}) begin errors++; $display("FAIL bp_bytes: got %h expected %h", packed_bytes(), {8'hAA, 8'h00, a, d}); end
        checks++; if (got_data !== 8'h33) begin errors++; $display("FAIL bp_data: got %h expected 33", got_data); end
    endtask

    task automatic test_timeout();
        int lat;
        run_txn(1'b0, 8'h44, 8'h55, 8'h00, 1'b1, 0, 0, -1, 0);
        lat = (wr_cyc.size() == 4 && resp_cyc >= 0) ? (resp_cyc - wr_cyc[3]) : -1;
        checks++; if (resp_n !== 1) begin errors++; $display("FAIL to_resps: got %0d expected 1", resp_n); end
        checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", got_err); end
        checks++; if (got_data !== 8'h00) begin errors++; $display("FAIL to_data: got %h expected 00", got_data); end
        checks++; if (ack_n !== 0) begin errors++; $display("FAIL to_acks: got %0d expected 0", ack_n); end
        checks++; if (!(lat >= TO && lat <= TO + 1)) begin errors++; $display("FAIL to_latency: got %0d expected %0d..%0d", lat, TO, TO + 1); end
    endtask

    task automatic test_reply_held();
        run_txn(1'b0, 8'h21, 8'h00, 8'h9E, 1'b0, 3, 0, -1, 0);
        checks++; if (ack_n !== 1) begin errors++; $display("FAIL held_acks: got %0d expected 1", ack_n); end
        checks++; if (resp_n !== 1) begin errors++; $display("FAIL held_resps: got %0d expected 1", resp_n); end
        checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL held_err: got %b expected 1", got_err); end
        checks++; if (got_data !== 8'h9E) begin errors++; $display("FAIL held_data: got %h expected 9e", got_data); end
    endtask

    task automatic test_reset_mid();
        int wr_seen = 0;
        logic [7:0] a = 8'($urandom);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h77; req_data = 8'h88; cmd_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (cmd_wr !== 1'b1 || cmd_out !== 8'h01) begin errors++; $display("FAIL rst_type_byte: got wr=%b out=%h expected wr=1 out=01", cmd_wr, cmd_out); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cmd_wr !== 1'b0) begin errors++; $display("FAIL rst_async_cmd_wr: got %b expected 0", cmd_wr); end
        checks++; if ({req_ready, cmd_out, reply_ack, resp_valid, resp_data, resp_err} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0})
            begin errors++; $display("FAIL rst_async_outputs: got rdy=%b out=%h ack=%b rv=%b rd=%h re=%b expected reset values", req_ready, cmd_out, reply_ack, resp_valid, resp_data, resp_err); end
        repeat (3) begin @(negedge clk); if (cmd_wr) wr_seen++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (cmd_wr) wr_seen++; end
        checks++; if (wr_seen !== 0) begin errors++; $display("FAIL rst_no_bytes: got %0d strobes expected 0", wr_seen); end
        run_txn(1'b0, a, 8'h10, 8'h6B, 1'b1, 1, 1, -1, 0);
        checks++; if (packed_bytes() !== {8'hAA, 8'h00, a, 8'h10}) begin errors++; $display("FAIL rst_next_bytes: got %h expected %h", packed_bytes(), {8'hAA, 8'h00, a, 8'h10}); end
        checks++; if (got_data !== 8'h6B || got_err !== 1'b0) begin errors++; $display("FAIL rst_next_resp: got %h/%b expected 6b/0", got_data, got_err); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic       wr = 1'($urandom);
            logic [7:0] a  = 8'($urandom);
            logic [7:0] d  = 8'($urandom);
            logic [7:0] rv = 8'($urandom);
            logic       re = ($urandom % 3 != 0);
            logic       noreply = ($urandom % 6 == 0);
            int         hold = noreply ? 0 : int'($urandom_range(1, 3));
            int         delay = int'($urandom_range(0, 5));
            int         bpi = int'($urandom_range(0, 3));
            int         bpl = int'($urandom_range(0, 3));
            logic [7:0] exp_d   = noreply ? 8'h00 : rv;
            logic       exp_e   = noreply || !re;
            int         exp_ack = noreply ? 0 : 1;
            run_txn(wr, a, d, rv, re, hold, delay, bpi, bpl);
            checks++; if (packed_bytes() !== {MAGIC, 7'b0, wr, a, d} || bytes.size() != 4) begin errors++; $display("FAIL rnd%0d_bytes: got %h (%0d) expected %h", n, packed_bytes(), bytes.size(), {MAGIC, 7'b0, wr, a, d}); end
            checks++; if (ack_n !== exp_ack) begin errors++; $display("FAIL rnd%0d_acks: got %0d expected %0d", n, ack_n, exp_ack); end
            checks++; if (resp_n !== 1) begin errors++; $display("FAIL rnd%0d_resps: got %0d expected 1", n, resp_n); end
            checks++; if (got_data !== exp_d || got_err !== exp_e) begin errors++; $display("FAIL rnd%0d_resp: got %h/%b expected %h/%b", n, got_data, got_err, exp_d, exp_e); end
            checks++; if (stall_wr !== 0 || stall_bad !== 0) begin errors++; $display("FAIL rnd%0d_stall: got wr=%0d bad=%0d expected 0/0", n, stall_wr, stall_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_timeout();
        test_reply_held();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
